// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - front-end fetch stage feeding instruction_decoder
//
// Issues one word fetch at a time to instruction memory and presents one
// instruction per cycle to the decoder. Bubbles are 32'h0 with out_noop=1.
// Redirects from EX squash wrong-path responses.
//
// Parameters:
//   RESET_PC        first fetch address after reset (bits [1:0] ignored)
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   imem_req_valid  out  fetch request valid
//   imem_req_ready  in   memory accepts the request
//   imem_addr       out  word-aligned fetch address
//   imem_rsp_valid  in   response data valid
//   imem_rsp_ready  out  fetch accepts the response
//   imem_rsp_data   in   instruction word
//   out_instr       out  instruction to decode (0 on bubble)
//   out_pc          out  address of out_instr
//   out_noop        out  out_instr is a bubble
//   stall           in   decoder hazard stall, hold outputs
//   in_redirect     in   EX redirect strobe
//   in_redirect_pc  in   redirect target (bits [1:0] forced to 0)
// Configuration:
//   IF_PREFETCH_BUF_EN  adds a one-entry {data, pc} buffer so a response can
//                       be accepted while the decoder is stalled.

module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  output logic        imem_rsp_ready,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_noop,
  input  logic        stall,
  input  logic        in_redirect,
  input  logic [31:0] in_redirect_pc
);

  localparam logic [31:0] RESET_WPC = RESET_PC & 32'hFFFF_FFFC;

  typedef enum logic {
    S_REQ,
    S_WAIT
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        active;     // low only in the cycle right after reset release
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic        drop;
  // Set when a redirect lands on a presented-but-unaccepted request: the
  // request keeps its old address (held in req_pc) while fetch_pc already
  // points at the redirect target.
  logic        held;
  logic        req_hs;
  logic        rsp_hs;
  logic        rsp_take;   // accepted response that belongs on the right path

`ifdef IF_PREFETCH_BUF_EN
  logic        buf_valid;
  logic [31:0] buf_data;
  logic [31:0] buf_pc;

  assign imem_rsp_ready = !buf_valid;
`else
  assign imem_rsp_ready = !stall | in_redirect | drop;
`endif

  assign req_hs   = imem_req_valid & imem_req_ready;
  assign rsp_hs   = (state == S_WAIT) & imem_rsp_valid & imem_rsp_ready;
  assign rsp_take = rsp_hs & !drop & !in_redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_REQ;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    imem_req_valid = 1'b0;
    imem_addr      = fetch_pc;
    case (state)
      S_REQ: begin
        imem_req_valid = active;
        imem_addr      = held ? req_pc : fetch_pc;
        if (active && imem_req_ready) begin
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid && imem_rsp_ready) begin
          state_nx = S_REQ;
        end
      end
      default: state_nx = S_REQ;
    endcase
  end

  // Fetch pointer, outstanding-request tracking and squash flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      fetch_pc <= RESET_WPC;
      req_pc   <= RESET_WPC;
      drop     <= 1'b0;
      held     <= 1'b0;
    end else begin
      active <= 1'b1;

      if (in_redirect) begin
        fetch_pc <= in_redirect_pc & 32'hFFFF_FFFC;
      end else if (req_hs && !held) begin
        fetch_pc <= fetch_pc + 32'd4;
      end

      if (imem_req_valid && !held && (req_hs || in_redirect)) begin
        req_pc <= fetch_pc;
      end

      if (req_hs) begin
        held <= 1'b0;
      end else if (in_redirect && imem_req_valid) begin
        held <= 1'b1;
      end

      if (in_redirect) begin
        if (state == S_WAIT) begin
          // A response retiring in the redirect cycle is simply discarded.
          drop <= !rsp_hs;
        end else if (imem_req_valid) begin
          drop <= 1'b1;
        end
      end else if (rsp_hs) begin
        drop <= 1'b0;
      end
    end
  end

  // Decoder-facing output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_instr <= 32'h0;
      out_pc    <= RESET_WPC;
      out_noop  <= 1'b1;
`ifdef IF_PREFETCH_BUF_EN
      buf_valid <= 1'b0;
      buf_data  <= 32'h0;
      buf_pc    <= RESET_WPC;
`endif
    end else if (in_redirect) begin
      out_instr <= 32'h0;
      out_noop  <= 1'b1;
`ifdef IF_PREFETCH_BUF_EN
      buf_valid <= 1'b0;
`endif
    end else if (stall) begin
`ifdef IF_PREFETCH_BUF_EN
      if (rsp_take) begin
        buf_valid <= 1'b1;
        buf_data  <= imem_rsp_data;
        buf_pc    <= req_pc;
      end
`endif
    end
`ifdef IF_PREFETCH_BUF_EN
    else if (buf_valid) begin
      // Buffered word always drains before any newer response.
      out_instr <= buf_data;
      out_pc    <= buf_pc;
      out_noop  <= 1'b0;
      buf_valid <= 1'b0;
    end
`endif
    else if (rsp_take) begin
      out_instr <= imem_rsp_data;
      out_pc    <= req_pc;
      out_noop  <= 1'b0;
    end else begin
      out_instr <= 32'h0;
      out_noop  <= 1'b1;
    end
  end

endmodule
